// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV64 core: latches the decode bundle, detects
// load-use hazards, inserts bubbles on stall/flush and keeps saturating event counters.
module id_ex_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             branch,
  input  logic             memread,
  input  logic             memtoreg,
  input  logic             memwrite,
  input  logic             aluSrc,
  input  logic             regwrite,
  input  logic [1:0]       Aluop,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [3:0]       id_funct4,
  input  logic             flush,
  output logic             stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             ex_valid,
  output logic             ex_branch,
  output logic             ex_memread,
  output logic             ex_memtoreg,
  output logic             ex_memwrite,
  output logic             ex_aluSrc,
  output logic             ex_regwrite,
  output logic [1:0]       ex_Aluop,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_funct4,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             vld_p1;
  logic [5:0]       ctl_p1;
  logic [1:0]       aluop_p1;
  logic [XLEN-1:0]  pc_p1, rs1d_p1, rs2d_p1, imm_p1;
  logic [4:0]       rs1_p1, rs2_p1, rd_p1;
  logic [3:0]       f4_p1;
  logic [CNT_W-1:0] scnt, fcnt;
  logic             haz;
  logic [5:0]       ctl_p0;

  // Stage p0: hazard detection on registered EX state against decode operands
  always_comb begin
    haz    = vld_p1 & ctl_p1[4] & (rd_p1 != 5'd0) & id_valid &
             ((rd_p1 == id_rs1) | (rd_p1 == id_rs2));
    ctl_p0 = {branch, memread, memtoreg, memwrite, aluSrc, regwrite} & {6{id_valid}};
  end

  assign stall       = haz & ~flush;
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;

  // Stage p1: ID/EX register; bubbles zero the whole bundle, dead slots only the control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      ctl_p1   <= '0;
      aluop_p1 <= '0;
      pc_p1    <= '0;
      rs1d_p1  <= '0;
      rs2d_p1  <= '0;
      imm_p1   <= '0;
      rs1_p1   <= '0;
      rs2_p1   <= '0;
      rd_p1    <= '0;
      f4_p1    <= '0;
      scnt     <= '0;
      fcnt     <= '0;
    end else if (flush || stall) begin
      vld_p1   <= 1'b0;
      ctl_p1   <= '0;
      aluop_p1 <= '0;
      pc_p1    <= '0;
      rs1d_p1  <= '0;
      rs2d_p1  <= '0;
      imm_p1   <= '0;
      rs1_p1   <= '0;
      rs2_p1   <= '0;
      rd_p1    <= '0;
      f4_p1    <= '0;
      if (flush) fcnt <= sat_inc(fcnt);
      else       scnt <= sat_inc(scnt);
    end else begin
      vld_p1   <= id_valid;
      ctl_p1   <= ctl_p0;
      aluop_p1 <= Aluop & {2{id_valid}};
      pc_p1    <= id_pc;
      rs1d_p1  <= id_rs1_data;
      rs2d_p1  <= id_rs2_data;
      imm_p1   <= id_imm;
      rs1_p1   <= id_rs1;
      rs2_p1   <= id_rs2;
      rd_p1    <= id_rd;
      f4_p1    <= id_funct4;
    end
  end

  assign ex_valid    = vld_p1;
  assign ex_branch   = ctl_p1[5];
  assign ex_memread  = ctl_p1[4];
  assign ex_memtoreg = ctl_p1[3];
  assign ex_memwrite = ctl_p1[2];
  assign ex_aluSrc   = ctl_p1[1];
  assign ex_regwrite = ctl_p1[0];
  assign ex_Aluop    = aluop_p1;
  assign ex_pc       = pc_p1;
  assign ex_rs1_data = rs1d_p1;
  assign ex_rs2_data = rs2d_p1;
  assign ex_imm      = imm_p1;
  assign ex_rs1      = rs1_p1;
  assign ex_rs2      = rs2_p1;
  assign ex_rd       = rd_p1;
  assign ex_funct4   = f4_p1;
  assign stall_cnt   = scnt;
  assign flush_cnt   = fcnt;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV64 core, directly downstream of the decode control unit.
- Latches that unit's control bundle, register operands, immediate and register indices.
- Owns load-use hazard detection: drives `stall` back into the control unit and freezes PC/IF-ID.
- Inserts bubbles on stall or flush, and keeps saturating bubble/flush counters for performance debug.

Parameters:
- XLEN, 64, datapath width of PC, operands and immediate.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  IF/ID holds a real instruction.
- branch, memread, memtoreg, memwrite, aluSrc, regwrite  input  1 each  control bits from the decode control unit.
- Aluop  input  2  ALU op class from the decode control unit.
- id_pc  input  XLEN  PC of the decode instruction.
- id_rs1_data, id_rs2_data  input  XLEN  register file read data.
- id_imm  input  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  input  5 each  register indices.
- id_funct4  input  4  {funct7[5], funct3}.
- flush  input  1  branch taken, resolved downstream; kill the decode instruction.
- stall  output  1  load-use hazard, combinational; feeds the control unit.
- pc_write  output  1  PC load enable.
- if_id_write  output  1  IF/ID load enable.
- ex_valid  output  1  EX holds a real instruction.
- ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_aluSrc, ex_regwrite  output  1 each  registered control bits.
- ex_Aluop  output  2  registered ALU op class.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  output  XLEN each  registered data.
- ex_rs1, ex_rs2, ex_rd  output  5 each  registered indices.
- ex_funct4  output  4  registered funct bits.
- stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Behaviour:
- Reset: rst_n low asynchronously clears every registered output, including ex_valid and both counters, to 0.
  - While rst_n is low: stall=0, pc_write=1, if_id_write=1.
  - Reset mid-stall discards the hazard; the first post-reset cycle is never stalled.
- Hazard (combinational, from registered EX state plus decode inputs):
  - haz = ex_valid & ex_memread & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - The rs2 compare is always applied (conservative for I-type).
- stall = haz & ~flush.
- pc_write = if_id_write = ~stall.
- Register update at each rising edge, priority highest first:
  1. Flush: load a bubble. flush_cnt += 1, saturating at all-ones.
  2. Stall: load a bubble. stall_cnt += 1, saturating.
  3. Otherwise: capture all id_* and control inputs; ex_valid = id_valid.
- Bubble definition: ex_valid=0; all control bits and ex_Aluop = 0; all data, index and funct fields = 0.
  - This applies regardless of the control inputs; the block does not rely on the control unit zeroing on stall.
- id_valid=0 without stall/flush: capture as normal, but force all control bits to 0 so a dead slot never writes a register or memory.
- Latency: exactly 1 cycle from ID inputs to ex_* outputs.
- A load-use stall lasts exactly 1 cycle.
  - After the bubble, ex_memread=0, so haz clears.
  - The held instruction then advances.
- Simultaneous flush and haz:
  - Flush wins, stall=0, pc_write=1.
  - Only flush_cnt increments.
- Counters saturate and never wrap.
- Counters clear only on reset.

Test Plan:
- Reset: hold rst_n=0 mid-operation with a pending hazard -> all ex_* = 0, ex_valid=0, stall=0, pc_write=1; counters 0 after release.
- Pass-through: add x5,x6,x7 (regwrite=1, Aluop=2'b10, id_rs1_data=0x10), no hazard -> next edge ex_regwrite=1, ex_Aluop=2'b10, ex_rs1_data=0x10, ex_valid=1.
- Load-use:
  - Stimulus: ld x5 (memread=1, rd=5) is in EX; decode presents add with rs1=5.
  - Same cycle: stall=1, pc_write=0, if_id_write=0.
  - Next edge: bubble (ex_valid=0, all control bits 0), stall_cnt=1.
  - Following edge: add captured.
- x0 exception: load to rd=0, decode uses rs1=0 -> stall stays 0, no bubble.
- Flush plus hazard: load-use condition with flush=1 -> stall=0, pc_write=1, bubble loaded, flush_cnt=1, stall_cnt unchanged.
- Saturation: with CNT_W=4, drive 20 load-use stalls -> stall_cnt stops at 15 and holds.
